// File: rtl/vga_scan_gen_if.sv
// VGA scan bundle: pixel coordinates, pixel enable, blanking, syncs and frame pulse.
// The generator drives it through master; overlays and sinks read it through slave.
interface vga_scan_gen_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       p_tick;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic       frame_tick;

  modport master (
    output x, y, p_tick, video_on, hsync, vsync, frame_tick
  );

  modport slave (
    input x, y, p_tick, video_on, hsync, vsync, frame_tick
  );
endinterface

// File: rtl/vga_scan_gen.sv
// VGA raster scan generator: clk/2 pixel enable, h/v counters, registered active-low syncs.
// Optional macro VGA_FRAME_TICK_EN adds a one-clk pulse at the start of vertical blanking.
module vga_scan_gen #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic           clk,
  input  logic           reset_n,
  vga_scan_gen_if.master vga
);

  localparam logic [9:0] H_DISP_W = 10'(H_DISPLAY);
  localparam logic [9:0] V_DISP_W = 10'(V_DISPLAY);
  localparam logic [9:0] H_LAST   = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST   = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic       div_q, div_d;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       p_tick;
  logic       h_wrap;

  // Syncs are decoded from the next counter values so they change on the same edge as the counters.
  always_comb begin
    div_d   = ~div_q;
    p_tick  = div_q;
    h_wrap  = (h_cnt_q == H_LAST);
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (p_tick) begin
      if (h_wrap) begin
        h_cnt_d = '0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d = '0;
        end else begin
          v_cnt_d = v_cnt_q + 10'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
    hsync_d = !((h_cnt_d >= HS_FIRST) && (h_cnt_d <= HS_LAST));
    vsync_d = !((v_cnt_d >= VS_FIRST) && (v_cnt_d <= VS_LAST));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= 1'b0;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      div_q   <= div_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

`ifdef VGA_FRAME_TICK_EN
  logic frame_tick_q, frame_tick_d;

  // Fires on the pixel edge that moves the scan from the last visible line into blanking.
  always_comb begin
    frame_tick_d = p_tick && h_wrap && (v_cnt_q == (V_DISP_W - 10'd1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= frame_tick_d;
    end
  end

  assign vga.frame_tick = frame_tick_q;
`else
  assign vga.frame_tick = 1'b0;
`endif

  assign vga.x        = h_cnt_q;
  assign vga.y        = v_cnt_q;
  assign vga.p_tick   = p_tick;
  assign vga.hsync    = hsync_q;
  assign vga.vsync    = vsync_q;
  assign vga.video_on = (h_cnt_q < H_DISP_W) && (v_cnt_q < V_DISP_W);

endmodule

// File: doc/vga_scan_gen.md
VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

Interface
REQ-001 SHALL have parameters: H_DISPLAY 640, visible pixels per line; H_FRONT 16, h front porch; H_SYNC 96, h sync width; H_BACK 48, h back porch; V_DISPLAY 480, visible lines; V_FRONT 10, v front porch; V_SYNC 2, v sync lines; V_BACK 33, v back porch.
REQ-002 SHALL have ports: clk, input, 1, 50 MHz system clock; reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports: x, output, 10, current pixel column; y, output, 10, current line; p_tick, output, 1, one-clk pixel-enable pulse (25 MHz rate).
REQ-004 SHALL have ports: video_on, output, 1, high while x/y lie in the visible area; hsync, output, 1, active-low horizontal sync; vsync, output, 1, active-low vertical sync; frame_tick, output, 1, one-clk start-of-vblank pulse.

Function
REQ-005 SHALL divide clk by 2 with a 1-bit toggle register; p_tick SHALL be high on every second clk cycle, starting with the 2nd clk cycle after reset release.
REQ-006 SHALL hold a horizontal counter h_cnt (0..H_TOTAL-1, H_TOTAL = sum of H params = 800) that advances only on cycles where p_tick is high.
REQ-007 h_cnt SHALL wrap from H_TOTAL-1 to 0 on a p_tick cycle; no value >= H_TOTAL SHALL ever appear.
REQ-008 SHALL hold a vertical counter v_cnt (0..V_TOTAL-1, V_TOTAL = 525) that increments only on the p_tick cycle where h_cnt wraps.
REQ-009 v_cnt SHALL wrap from V_TOTAL-1 to 0 when both counters wrap on the same p_tick; this ends the frame.
REQ-010 x SHALL equal h_cnt and y SHALL equal v_cnt, both registered with no added latency.
REQ-011 video_on SHALL be high iff x < H_DISPLAY and y < V_DISPLAY.
REQ-012 hsync SHALL be a registered output, low iff h_cnt is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] (656..751), updated on the same edge as h_cnt.
REQ-013 vsync SHALL be a registered output, low iff v_cnt is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] (490..491), updated on the same edge as v_cnt.
REQ-014 Downstream overlays SHALL be able to sample x/y and present ROM data (1-clk synchronous ROM) within the same pixel period; x/y SHALL therefore stay stable for the full 2-clk pixel period.
REQ-015 Counter widths SHALL be 10 bits; all comparisons unsigned.

Reset
REQ-016 On reset_n low, asynchronously: divider 0; h_cnt, v_cnt, x, y 0; p_tick 0; hsync 1; vsync 1; frame_tick 0. video_on SHALL follow from x = y = 0, i.e. 1.
REQ-017 Reset asserted mid-frame SHALL return all state to REQ-016 values immediately; after release, the scan SHALL restart at x = 0, y = 0 with no partial-line carry-over.

Configuration
REQ-018 Macro VGA_FRAME_TICK_EN: when defined, frame_tick SHALL pulse high for exactly one clk on the p_tick cycle where v_cnt changes from V_DISPLAY-1 to V_DISPLAY (line 479 to 480), once per frame; when undefined, frame_tick SHALL be tied 0 and no related logic synthesized.

Verification
REQ-019 Reset release, run 4 clk -> p_tick pattern 0,1,0,1; x advances 0->1 only after the first p_tick.
REQ-020 Run to x = 799, y = 0, then one p_tick -> x = 0, y = 1; hsync low exactly for x = 656..751 (96 pixels, 192 clk).
REQ-021 Run a full frame -> x = 799, y = 524 then x = 0, y = 0; vsync low for exactly lines 490..491 (1600 pixel ticks); frame period 420000 p_ticks.
REQ-022 Sample video_on at (639,479) = 1, (640,479) = 0, (639,480) = 0, (0,0) = 1.
REQ-023 Assert reset_n low at x = 300, y = 200 mid-clock -> outputs take REQ-016 values without waiting for a clk edge; after release, the scan restarts from (0,0).
REQ-024 With VGA_FRAME_TICK_EN defined, run 3 frames -> exactly 3 one-clk frame_tick pulses, each at the transition to y = 480, x = 0; undefined -> frame_tick constantly 0.
